// File: rtl/calc_pkg.sv
// Shared types for the decimal calculator core: command codes, FSM states,
// status codes and the seven-segment digit encoder.
package calc_pkg;

   typedef enum logic [3:0] {
      CMD_ADD = 4'hA,
      CMD_SUB = 4'hB,
      CMD_MUL = 4'hC,
      CMD_DIV = 4'hD,
      CMD_EQ  = 4'hE,
      CMD_BS  = 4'hF
   } cmd_e;

   typedef enum logic [2:0] {
      ST_ENTRY_A = 3'd0,
      ST_OP_WAIT = 3'd1,
      ST_ENTRY_B = 3'd2,
      ST_COMPUTE = 3'd3,
      ST_CONVERT = 3'd4,
      ST_RESULT  = 3'd5,
      ST_ERROR   = 3'd6
   } state_e;

   typedef enum logic [1:0] {
      STAT_READY = 2'b00,
      STAT_BUSY  = 2'b01,
      STAT_ERROR = 2'b10
   } status_e;

   localparam logic [6:0] SEG_BLANK = 7'b0000000;
   localparam logic [6:0] SEG_ZERO  = 7'b0111111;
   localparam logic [6:0] SEG_E     = 7'b1111001;

   // Segment order {g,f,e,d,c,b,a}, active-high.
   function automatic logic [6:0] seg7(input logic [3:0] d);
      logic [6:0] s;
      s = SEG_BLANK;
      case (d)
         4'd0: s = 7'b0111111;
         4'd1: s = 7'b0000110;
         4'd2: s = 7'b1011011;
         4'd3: s = 7'b1001111;
         4'd4: s = 7'b1100110;
         4'd5: s = 7'b1101101;
         4'd6: s = 7'b1111101;
         4'd7: s = 7'b0000111;
         4'd8: s = 7'b1111111;
         4'd9: s = 7'b1101111;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/calc_bin2bcd.sv
// Iterative shift-add-3 binary to BCD converter; one bit per cycle, done_o
// pulses for one cycle once bcd_o holds the converted value.
module calc_bin2bcd #(
   parameter int VW      = 27,
   parameter int NDIGITS = 8
) (
   input  logic                   clock_i,
   input  logic                   reset_i,
   input  logic                   start_i,
   input  logic [VW-1:0]          bin_i,
   output logic                   done_o,
   output logic [4*NDIGITS-1:0]   bcd_o
);
   localparam int CW = $clog2(VW + 1);

   logic [VW-1:0]        bin_q;
   logic [4*NDIGITS-1:0] bcd_q;
   logic [4*NDIGITS-1:0] bcd_adj;
   logic [CW-1:0]        cnt_q;
   logic                 busy_q;
   logic                 done_q;

   for (genvar gi = 0; gi < NDIGITS; gi++) begin : g_adj
      assign bcd_adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ? bcd_q[4*gi +: 4] + 4'd3
                                                              : bcd_q[4*gi +: 4];
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         bin_q  <= '0;
         bcd_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (start_i) begin
            bin_q  <= bin_i;
            bcd_q  <= '0;
            cnt_q  <= CW'(VW);
            busy_q <= 1'b1;
         end else if (busy_q) begin
            bcd_q <= {bcd_adj[4*NDIGITS-2:0], bin_q[VW-1]};
            bin_q <= {bin_q[VW-2:0], 1'b0};
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               busy_q <= 1'b0;
               done_q <= 1'b1;
            end
         end
      end
   end

   assign done_o = done_q;
   assign bcd_o  = bcd_q;

endmodule

// File: rtl/calc_core_p.sv
// Decimal four-function calculator: keypad command FSM, sequential mul/div
// datapath sharing one bit counter, and seven-segment display formatting.
module calc_core_p
   import calc_pkg::*;
#(
   parameter int NDIGITS = 8
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [3:0]                cmd,
   input  logic                      cmd_valid,
   output logic [NDIGITS-1:0][6:0]   displays,
   output logic [1:0]                status,
   output logic [2:0]                state
);
   localparam int VW = $clog2(10**NDIGITS);
   localparam int CW = $clog2(VW);
   localparam logic [VW-1:0] MAXV = VW'(10**NDIGITS - 1);
   localparam logic [VW-1:0] LIM  = VW'(10**(NDIGITS - 1));
   localparam logic [VW-1:0] TEN  = VW'(10);

   state_e state_q, state_d, ret_q, ret_d;
   logic [VW-1:0] entry_q, entry_d, a_q, a_d, b_q, b_d, result_q, result_d;
   logic [3:0] op_q, op_d, nop_q, nop_d;
   logic chain_q, chain_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2*VW-1:0] acc_q, acc_d, mul_nx;
   logic [VW-1:0] rem_q, rem_d, quo_q, quo_d, quo_nx;
   logic [VW:0] sum, rem_sh, rem_nx;
   logic div_ge;
   logic [NDIGITS-1:0][6:0] disp_q, disp_d, fmt;
   logic conv_start, conv_done, fin, fail;
   logic [VW-1:0] conv_val, res_v, digit_v;
   logic [4*NDIGITS-1:0] bcd;
   logic is_digit, is_op;

   assign digit_v  = {{(VW-4){1'b0}}, cmd};
   assign is_digit = (cmd <= 4'd9);
   assign is_op    = (cmd >= CMD_ADD) && (cmd <= CMD_DIV);

   assign sum    = {1'b0, a_q} + {1'b0, b_q};
   assign mul_nx = (acc_q << 1) + (b_q[cnt_q] ? {{VW{1'b0}}, a_q} : '0);
   assign rem_sh = {rem_q, quo_q[VW-1]};
   assign div_ge = (rem_sh >= {1'b0, b_q});
   assign rem_nx = div_ge ? rem_sh - {1'b0, b_q} : rem_sh;
   assign quo_nx = {quo_q[VW-2:0], div_ge};

   calc_bin2bcd #(.VW(VW), .NDIGITS(NDIGITS)) u_bin2bcd (
      .clock_i (clock),
      .reset_i (reset),
      .start_i (conv_start),
      .bin_i   (conv_val),
      .done_o  (conv_done),
      .bcd_o   (bcd)
   );

   // Leading zeros blank; the units digit always shows.
   always_comb begin
      logic lead;
      fmt  = '0;
      lead = 1'b1;
      for (int i = NDIGITS - 1; i >= 0; i--) begin
         if (lead && (bcd[4*i +: 4] == 4'd0) && (i != 0)) begin
            fmt[i] = SEG_BLANK;
         end else begin
            fmt[i] = seg7(bcd[4*i +: 4]);
            lead   = 1'b0;
         end
      end
   end

   always_comb begin
      state_d = state_q;  ret_d = ret_q;
      entry_d = entry_q;  a_d = a_q;  b_d = b_q;  result_d = result_q;
      op_d = op_q;  nop_d = nop_q;  chain_d = chain_q;
      cnt_d = cnt_q;  acc_d = acc_q;  rem_d = rem_q;  quo_d = quo_q;
      disp_d = disp_q;
      conv_start = 1'b0;  conv_val = '0;
      fin = 1'b0;  fail = 1'b0;  res_v = '0;
      case (state_q)
         ST_ENTRY_A, ST_ENTRY_B: if (cmd_valid) begin
            if (is_digit || cmd == CMD_BS) begin
               res_v = (state_q == ST_ENTRY_A) ? entry_q : b_q;
               if (cmd == CMD_BS)    res_v = res_v / TEN;
               else if (res_v < LIM) res_v = res_v * TEN + digit_v;
               if (state_q == ST_ENTRY_A) entry_d = res_v;
               else                       b_d = res_v;
               conv_start = 1'b1;  conv_val = res_v;
               ret_d = state_q;  state_d = ST_CONVERT;
            end else if (state_q == ST_ENTRY_A) begin
               if (is_op) begin
                  op_d = cmd;  a_d = entry_q;  state_d = ST_OP_WAIT;
               end
            end else begin
               // Equals or a chained operator: start the pending operation.
               chain_d = is_op;  nop_d = cmd;
               cnt_d = CW'(VW - 1);  acc_d = '0;  rem_d = '0;  quo_d = a_q;
               state_d = ST_COMPUTE;
            end
         end
         ST_OP_WAIT: if (cmd_valid) begin
            if (is_op) begin
               op_d = cmd;
            end else if (is_digit) begin
               b_d = digit_v;
               conv_start = 1'b1;  conv_val = digit_v;
               ret_d = ST_ENTRY_B;  state_d = ST_CONVERT;
            end
         end
         ST_COMPUTE: begin
            case (op_q)
               CMD_ADD: begin
                  fin = 1'b1;  res_v = sum[VW-1:0];  fail = (sum > {1'b0, MAXV});
               end
               CMD_SUB: begin
                  fin = 1'b1;  res_v = a_q - b_q;  fail = (a_q < b_q);
               end
               CMD_MUL: begin
                  acc_d = mul_nx;  cnt_d = cnt_q - CW'(1);
                  fin   = (cnt_q == '0);
                  res_v = mul_nx[VW-1:0];
                  fail  = (mul_nx > {{VW{1'b0}}, MAXV});
               end
               default: begin
                  rem_d = rem_nx[VW-1:0];  quo_d = quo_nx;  cnt_d = cnt_q - CW'(1);
                  fin   = (cnt_q == '0) || (b_q == '0);
                  fail  = (b_q == '0);
                  res_v = quo_nx;
               end
            endcase
            if (fin && fail) begin
               state_d = ST_ERROR;  chain_d = 1'b0;
               disp_d = '0;  disp_d[0] = SEG_E;
            end else if (fin) begin
               result_d = res_v;
               conv_start = 1'b1;  conv_val = res_v;
               state_d = ST_CONVERT;  ret_d = ST_RESULT;
               if (chain_q) begin
                  a_d = res_v;  op_d = nop_q;  chain_d = 1'b0;  ret_d = ST_OP_WAIT;
               end
            end
         end
         ST_CONVERT: if (conv_done) begin
            disp_d = fmt;  state_d = ret_q;
         end
         ST_RESULT, ST_ERROR: if (cmd_valid) begin
            if (is_op && state_q == ST_RESULT) begin
               op_d = cmd;  a_d = result_q;  state_d = ST_OP_WAIT;
            end else if (is_digit) begin
               entry_d = digit_v;
               conv_start = 1'b1;  conv_val = digit_v;
               ret_d = ST_ENTRY_A;  state_d = ST_CONVERT;
            end
         end
         default: state_d = ST_ENTRY_A;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_ENTRY_A;  ret_q <= ST_ENTRY_A;
         entry_q <= '0;  a_q <= '0;  b_q <= '0;  result_q <= '0;
         op_q <= '0;  nop_q <= '0;  chain_q <= 1'b0;
         cnt_q <= '0;  acc_q <= '0;  rem_q <= '0;  quo_q <= '0;
         disp_q    <= '0;
         disp_q[0] <= SEG_ZERO;
      end else begin
         state_q <= state_d;  ret_q <= ret_d;
         entry_q <= entry_d;  a_q <= a_d;  b_q <= b_d;  result_q <= result_d;
         op_q <= op_d;  nop_q <= nop_d;  chain_q <= chain_d;
         cnt_q <= cnt_d;  acc_q <= acc_d;  rem_q <= rem_d;  quo_q <= quo_d;
         disp_q <= disp_d;
      end
   end

   always_comb begin
      case (state_q)
         ST_COMPUTE, ST_CONVERT: status = STAT_BUSY;
         ST_ERROR:               status = STAT_ERROR;
         default:                status = STAT_READY;
      endcase
   end

   assign displays = disp_q;
   assign state    = state_q;

endmodule

// File: tb/tb_calc_core_p.sv
// Drives an 8-digit and a 4-digit calculator with the same keypad stream and
// compares both against a plain-arithmetic calculator model.
module tb_calc_core_p;
   import calc_pkg::*;

   localparam int M_A = 0, M_OPW = 1, M_B = 2, M_RES = 3, M_ERR = 4;

   typedef struct {
      int     md;
      longint entry, a, b, res;
      int     op;
   } mdl_t;

   logic clock = 1'b0;
   logic reset;
   logic [3:0] cmd;
   logic cmd_valid;
   logic [7:0][6:0] disp8;
   logic [3:0][6:0] disp4;
   logic [1:0] status8, status4;
   logic [2:0] state8, state4;

   int n_vec = 0;
   int n_err = 0;
   mdl_t m [2];
   int nd [2] = '{8, 4};
   logic [6:0] segtab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

   always #5 clock = ~clock;

   calc_core_p #(.NDIGITS(8)) dut8 (
      .clock(clock), .reset(reset), .cmd(cmd), .cmd_valid(cmd_valid),
      .displays(disp8), .status(status8), .state(state8)
   );
   calc_core_p #(.NDIGITS(4)) dut4 (
      .clock(clock), .reset(reset), .cmd(cmd), .cmd_valid(cmd_valid),
      .displays(disp4), .status(status4), .state(state4)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic longint pow10(input int n);
      longint p = 1;
      for (int i = 0; i < n; i++) p = p * 10;
      return p;
   endfunction

   function automatic longint apply_op(input int op, input longint a, input longint b);
      case (op)
         10: return a + b;
         11: return a - b;
         12: return a * b;
         default: return (b == 0) ? -1 : a / b;
      endcase
   endfunction

   task automatic mdl_reset();
      for (int k = 0; k < 2; k++) begin
         m[k].md = M_A;  m[k].entry = 0;  m[k].a = 0;
         m[k].b = 0;     m[k].res = 0;    m[k].op = 0;
      end
   endtask

   task automatic mdl_step(input int k, input int c);
      longint lim, maxv, r;
      bit dig, isop;
      lim  = pow10(nd[k] - 1);
      maxv = pow10(nd[k]) - 1;
      dig  = (c <= 9);
      isop = (c >= 10 && c <= 13);
      case (m[k].md)
         M_A: begin
            if (dig) begin
               if (m[k].entry < lim) m[k].entry = m[k].entry * 10 + c;
            end else if (c == 15) m[k].entry = m[k].entry / 10;
            else if (isop) begin
               m[k].op = c;  m[k].a = m[k].entry;  m[k].md = M_OPW;
            end
         end
         M_OPW: begin
            if (isop) m[k].op = c;
            else if (dig) begin m[k].b = c;  m[k].md = M_B; end
         end
         M_B: begin
            if (dig) begin
               if (m[k].b < lim) m[k].b = m[k].b * 10 + c;
            end else if (c == 15) m[k].b = m[k].b / 10;
            else begin
               r = apply_op(m[k].op, m[k].a, m[k].b);
               if (r < 0 || r > maxv) m[k].md = M_ERR;
               else begin
                  m[k].res = r;
                  if (isop) begin m[k].a = r;  m[k].op = c;  m[k].md = M_OPW; end
                  else m[k].md = M_RES;
               end
            end
         end
         M_RES: begin
            if (isop) begin m[k].op = c;  m[k].a = m[k].res;  m[k].md = M_OPW; end
            else if (dig) begin m[k].entry = c;  m[k].md = M_A; end
         end
         default: if (dig) begin m[k].entry = c;  m[k].md = M_A; end
      endcase
   endtask

   function automatic logic [63:0] exp_disp(input int k);
      logic [63:0] v = '0;
      longint x;
      if (m[k].md == M_ERR) begin
         v[6:0] = 7'b1111001;
         return v;
      end
      case (m[k].md)
         M_A:     x = m[k].entry;
         M_OPW:   x = m[k].a;
         M_B:     x = m[k].b;
         default: x = m[k].res;
      endcase
      for (int i = 0; i < nd[k]; i++) begin
         if (i == 0 || x != 0) v[7*i +: 7] = segtab[int'(x % 10)];
         x = x / 10;
      end
      return v;
   endfunction

   function automatic logic [63:0] exp_stat(input int k);
      return (m[k].md == M_ERR) ? 64'd2 : 64'd0;
   endfunction

   task automatic check_outputs();
      check("disp8", {8'b0, disp8}, exp_disp(0));
      check("stat8", 64'(status8), exp_stat(0));
      check("disp4", {36'b0, disp4}, exp_disp(1));
      check("stat4", 64'(status4), exp_stat(1));
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b1;  cmd_valid = 1'b0;
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
      mdl_reset();
      check("state8_rst", 64'(state8), 64'(ST_ENTRY_A));
      check("state4_rst", 64'(state4), 64'(ST_ENTRY_A));
      check_outputs();
      $display("reset: disp8=%h disp4=%h", disp8, disp4);
   endtask

   task automatic send(input logic [3:0] c, input bit junk);
      int n = 0;
      @(negedge clock);
      cmd = c;  cmd_valid = 1'b1;
      @(negedge clock);
      cmd_valid = 1'b0;
      // A strobe while both cores are busy must be dropped entirely.
      if (junk && status8 == STAT_BUSY && status4 == STAT_BUSY) begin
         cmd = 4'($urandom_range(0, 15));  cmd_valid = 1'b1;
         @(negedge clock);
         cmd_valid = 1'b0;
      end
      while ((status8 == STAT_BUSY || status4 == STAT_BUSY) && n < 400) begin
         @(negedge clock);
         n++;
      end
      check("settle", 64'(status8 == STAT_BUSY || status4 == STAT_BUSY), 64'd0);
      for (int k = 0; k < 2; k++) mdl_step(k, int'(c));
      check_outputs();
      $display("cmd=%h st8=%0d st4=%0d disp8=%h disp4=%h", c, state8, state4, disp8, disp4);
   endtask

   task automatic play(input string s, input bit junk);
      logic [3:0] c;
      for (int i = 0; i < s.len(); i++) begin
         case (s[i])
            "+": c = 4'hA;
            "-": c = 4'hB;
            "*": c = 4'hC;
            "/": c = 4'hD;
            "=": c = 4'hE;
            "<": c = 4'hF;
            default: c = 4'(s[i] - "0");
         endcase
         send(c, junk);
      end
   endtask

   initial begin
      reset = 1'b1;  cmd = '0;  cmd_valid = 1'b0;
      mdl_reset();
      do_reset();
      play("123+1=", 0);
      do_reset();
      play("50-15=", 0);  play("3-5=", 0);  play("7", 0);
      do_reset();
      play("6*2=", 0);  play("100/7=", 0);  play("7/0=", 0);
      do_reset();
      play("456<", 0);  play("=+1=<", 0);
      do_reset();
      play("2+3+", 1);  play("4=", 1);
      do_reset();
      play("99999+1=", 0);
      do_reset();
      play("99*99", 0);
      // Abort a multiply mid-flight and confirm nothing partial appears.
      @(negedge clock);
      cmd = 4'hE;  cmd_valid = 1'b1;
      @(negedge clock);
      cmd_valid = 1'b0;
      repeat (3) @(negedge clock);
      check("busy8_mid", 64'(status8), 64'(STAT_BUSY));
      check("busy4_mid", 64'(status4), 64'(STAT_BUSY));
      do_reset();
      repeat (80) @(negedge clock);
      check_outputs();

      for (int t = 0; t < 300; t++) begin
         int r;
         if ($urandom_range(0, 59) == 0) do_reset();
         r = int'($urandom_range(0, 19));
         if (r < 10) send(4'(r), $urandom_range(0, 3) == 0);
         else        send(4'(10 + (r - 10) % 6), $urandom_range(0, 3) == 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/calc_core_p.md
CALC_CORE_P -- requirements
Module: calc_core_p

Interface
REQ-001 Parameter NDIGITS, default 8, number of decimal digits per operand, result and display (range 2..9).
REQ-002 Derived localparam VW = $clog2(10**NDIGITS) sets the operand width; MAXV = 10**NDIGITS-1.
REQ-003 clock  in  1  single clock; all logic is clocked on the rising edge.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 cmd  in  4  command code: 0-9 digit, 1010 add, 1011 sub, 1100 mul, 1101 div, 1110 equals, 1111 backspace.
REQ-006 cmd_valid  in  1  one-cycle strobe; cmd is sampled only when cmd_valid=1.
REQ-007 displays  out  7 x NDIGITS  seven-segment patterns, active-high, bit order {g,f,e,d,c,b,a}; displays[0] is the rightmost digit.
REQ-008 status  out  2  00 READY, 01 BUSY, 10 ERROR, 11 reserved (never driven).
REQ-009 state  out  3  current FSM state encoding, for debug.

Function
REQ-010 FSM states: ENTRY_A, OP_WAIT, ENTRY_B, COMPUTE, CONVERT, RESULT, ERROR.
REQ-011 A digit in ENTRY_A/ENTRY_B sets entry = entry*10 + d; the digit is ignored if entry already has NDIGITS significant digits.
REQ-012 Backspace in ENTRY_A/ENTRY_B sets entry = entry/10; backspace in OP_WAIT or RESULT is ignored.
REQ-013 An operator in ENTRY_A or RESULT stores the operator, copies entry/result to A and moves to OP_WAIT.
REQ-014 An operator in OP_WAIT replaces the pending operator only.
REQ-015 A digit in OP_WAIT clears B, loads the digit into B and moves to ENTRY_B.
REQ-016 Equals in ENTRY_B, or an operator in ENTRY_B (chaining), moves to COMPUTE; for chaining, the new operator is held pending and, after a successful computation, the FSM enters OP_WAIT with A = result.
REQ-017 Equals in ENTRY_A, OP_WAIT or RESULT is ignored.
REQ-018 Add/sub complete in 1 cycle; mul uses shift-add, 1 bit per cycle, VW cycles; div uses restoring division, VW cycles, producing the integer quotient.
REQ-019 Result > MAXV, sub result < 0, or div by 0 moves the FSM to ERROR.
REQ-020 A digit in RESULT or ERROR starts a new ENTRY_A holding that digit; other commands in ERROR are ignored.
REQ-021 Every change of the displayed value passes through CONVERT (binary-to-BCD, VW cycles); displays update on the cycle conversion completes.
REQ-022 Displayed value: entry in ENTRY_A/ENTRY_B, A in OP_WAIT, result in RESULT.
REQ-023 Leading zeros are blanked (all segments 0); displays[0] always shows a digit.
REQ-024 ERROR display: displays[0] shows "E" (7'b1111001); all other digits are blank.
REQ-025 status is BUSY in COMPUTE and CONVERT, ERROR in ERROR, and READY otherwise.
REQ-026 cmd_valid while BUSY is dropped, with no queueing and no side effect.
REQ-027 Latency from an accepted digit or backspace to updated displays is at most VW+3 cycles; for equals it is at most 2*VW+4 cycles.

Reset
REQ-028 While reset=1 at a clock edge: state = ENTRY_A, entry/A/B/result/op = 0, status = READY, displays[0] = "0" (7'b0111111), other digits blank.
REQ-029 Reset asserted mid-COMPUTE or mid-CONVERT aborts the operation; no partial result is ever displayed.

Structure
REQ-030 Package calc_pkg holds the cmd code enum, FSM state enum, status enum and the digit-to-segment function.
REQ-031 Sub-module calc_bin2bcd (parameters VW, NDIGITS; start/done handshake; iterative shift-add-3) performs conversion.
REQ-032 Multiply and divide are performed in calc_core_p with a shared VW-cycle counter.

Verification (NDIGITS=8 unless stated; wait for status==READY after each cmd_valid)
REQ-033 1,2,3,+,1,= -> displays read "124", status READY.
REQ-034 5,0,-,1,5,= -> "35"; 3,-,5,= -> status ERROR, displays[0] = "E"; then 7 -> "7", status READY.
REQ-035 6,*,2,= -> "12"; 1,0,0,/,7,= -> "14"; 7,/,0,= -> ERROR.
REQ-036 4,5,6,backspace -> "45"; =, then extra backspace -> "45" unchanged.
REQ-037 2,+,3,+ -> "5" in OP_WAIT; 4,= -> "9"; cmd_valid pulsed while BUSY -> ignored.
REQ-038 NDIGITS=4: 9,9,9,9,9 -> "9999" (fifth digit dropped); +,1,= -> ERROR; reset during COMPUTE -> "0", state ENTRY_A.
